data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 126 ++++++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
// data_sram_resp: single-port word SRAM with a fixed-depth in-order response
// queue. Requests are accepted on addr_ok; each accepted request produces
// exactly one data_ok pulse, in accept order.
// Optional build macro RANDOM_DELAY_EN: an LFSR throttles addr_ok and adds a
// 0..7 cycle wait before each head response, for requester stress testing.
module data_sram_resp #(
  parameter int IDX_W  = 10,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW     = $clog2(QDEPTH + 1);
  localparam int NWORDS = 1 << IDX_W;

  logic [31:0]      mem_q [NWORDS];
  logic [31:0]      dat_q [QDEPTH];
  logic [1:0]       sz_q  [QDEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0] idx;
  logic             space, accept, pop;

  // Upper address bits wrap; byte offset and size are not used for data.
  logic unused_bits;
  assign unused_bits = ^{addr[31:IDX_W+2], addr[1:0], sz_q[head_q]};

  assign idx    = addr[IDX_W+1:2];
  assign space  = (cnt_q < CW'(QDEPTH));
  assign accept = req & addr_ok;
  assign pop    = data_ok;
  assign rdata  = data_ok ? dat_q[head_q] : 32'h0;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QDEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

`ifdef RANDOM_DELAY_EN
  logic [7:0] lfsr_q;
  logic [2:0] wait_q, wait_d;

  assign addr_ok = resetn & space & ~lfsr_q[0];
  assign data_ok = (cnt_q != '0) & (wait_q == 3'd0);

  // Free-running Fibonacci LFSR, taps 8,6,5,4.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 8'hA5;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // Head wait: reload whenever a new entry becomes head, else count down.
  always_comb begin
    wait_d = wait_q;
    if ((cnt_d != '0) && ((cnt_q == '0) || pop)) wait_d = lfsr_q[3:1];
    else if (wait_q != 3'd0)                      wait_d = wait_q - 3'd1;
  end

  // Head wait counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wait_q <= 3'd0;
    else         wait_q <= wait_d;
  end
`else
  assign addr_ok = resetn & space;
  assign data_ok = (cnt_q != '0);
`endif

  // Queue pointer and occupancy next-state.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (accept) tail_d = ptr_inc(tail_q);
    if (pop)    head_d = ptr_inc(head_q);
    if (accept && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!accept && pop) cnt_d = cnt_q - 1'b1;
  end

  // Queue control registers; reset drops every pending response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Response payload capture: read data sampled at the accept edge, writes return 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < QDEPTH; i++) begin
        dat_q[i] <= 32'h0;
        sz_q[i]  <= 2'd0;
      end
    end else if (accept) begin
      dat_q[tail_q] <= wr ? 32'h0 : mem_q[idx];
      sz_q[tail_q]  <= size;
    end
  end

  // Byte-masked memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
